// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = (A - B) mod 2^W, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flip-flop.
// START is accepted only in IDLE. D/BOUT/ZERO are registered and change only
// on the edge that completes a computation.
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] D,
    output logic         BOUT,
    output logic         ZERO
);

    // Counter wide enough to hold 0..W-1 (at least one bit for W == 1).
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic a, input logic b, input logic c);
        fs_diff = a ^ b ^ c;
    endfunction

    // Full-subtractor borrow out: borrow when a < b + c.
    function automatic logic fs_borrow(input logic a, input logic b, input logic c);
        fs_borrow = (~a & b) | (~(a ^ b) & c);
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    sa_r;
    logic [W-1:0]    sb_r;
    logic [W-1:0]    res_r;
    logic            borrow_r;
    logic [CW-1:0]   cnt_r;

    logic            diff_bit_s;
    logic            borrow_nxt_s;
    logic            last_bit_s;
    logic [W-1:0]    dbit_msb_s;
    logic [W-1:0]    res_shift_s;

    // Serial datapath: one full-subtractor evaluation on the current LSBs,
    // result bit inserted at the MSB end so that after W shifts it is aligned.
    always_comb begin
        diff_bit_s   = fs_diff(sa_r[0], sb_r[0], borrow_r);
        borrow_nxt_s = fs_borrow(sa_r[0], sb_r[0], borrow_r);
        dbit_msb_s   = {W{1'b0}};
        dbit_msb_s[W-1] = diff_bit_s;
        res_shift_s  = (res_r >> 1'b1) | dbit_msb_s;
        last_bit_s   = (cnt_r == CNT_LAST);
    end

    // Next-state logic for the IDLE -> SHIFT -> FINISH sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand/result shift registers, borrow, counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sa_r     <= {W{1'b0}};
            sb_r     <= {W{1'b0}};
            res_r    <= {W{1'b0}};
            borrow_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            D        <= {W{1'b0}};
            BOUT     <= 1'b0;
            ZERO     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        sa_r     <= A;
                        sb_r     <= B;
                        res_r    <= {W{1'b0}};
                        borrow_r <= 1'b0;
                        cnt_r    <= {CW{1'b0}};
                        BUSY     <= 1'b1;
                    end else begin
                        BUSY     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    res_r    <= res_shift_s;
                    sa_r     <= sa_r >> 1'b1;
                    sb_r     <= sb_r >> 1'b1;
                    borrow_r <= borrow_nxt_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (last_bit_s) begin
                        // Final bit: publish the result in the same edge.
                        D    <= res_shift_s;
                        BOUT <= borrow_nxt_s;
                        ZERO <= (res_shift_s == {W{1'b0}});
                        BUSY <= 1'b0;
                        DONE <= 1'b1;
                    end else begin
                        BUSY <= 1'b1;
                        DONE <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    BUSY <= 1'b0;
                    DONE <= 1'b0;
                end
                default: begin
                    BUSY <= 1'b0;
                    DONE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes hand-computed
// expected results; per-DUT monitors pop and compare on every DONE pulse.
module tb_serial_subtractor;

    logic       CLK;
    logic       RST;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] d8;
    logic       bout8;
    logic       zero8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] d1;
    logic       bout1;
    logic       zero1;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       zero;
        int         acc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    int tests;
    int failed;
    int cyc;
    int done_cnt8;
    int done_cnt1;

    serial_subtractor #(.W(8)) dut8 (
        .CLK(CLK), .RST(RST), .START(start8), .A(a8), .B(b8),
        .BUSY(busy8), .DONE(done8), .D(d8), .BOUT(bout8), .ZERO(zero8)
    );

    serial_subtractor #(.W(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(start1), .A(a1), .B(b1),
        .BUSY(busy1), .DONE(done1), .D(d1), .BOUT(bout1), .ZERO(zero1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Edge counter used for latency checks.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor for the W=8 instance.
    always @(negedge CLK) begin
        if (done8 === 1'b1) begin
            exp_t e;
            done_cnt8++;
            if (q8.size() == 0) begin
                check("w8 unexpected DONE", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check("w8 D", {24'd0, d8}, {24'd0, e.d});
                check("w8 BOUT", {31'd0, bout8}, {31'd0, e.bout});
                check("w8 ZERO", {31'd0, zero8}, {31'd0, e.zero});
                check("w8 BUSY at DONE", {31'd0, busy8}, 32'd0);
                check("w8 latency", cyc - e.acc, 32'd8);
            end
        end
    end

    // Monitor for the W=1 instance.
    always @(negedge CLK) begin
        if (done1 === 1'b1) begin
            exp_t e;
            done_cnt1++;
            if (q1.size() == 0) begin
                check("w1 unexpected DONE", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("w1 D", {31'd0, d1}, {31'd0, e.d[0]});
                check("w1 BOUT", {31'd0, bout1}, {31'd0, e.bout});
                check("w1 ZERO", {31'd0, zero1}, {31'd0, e.zero});
                check("w1 latency", cyc - e.acc, 32'd1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Pulse START on the W=8 instance for one edge; push expectation if accepted.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input bit push,
                       input logic [7:0] d, input logic bout, input logic zero);
        exp_t e;
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        @(posedge CLK);
        #2;
        start8 = 1'b0;
        a8 = 8'hA5;
        b8 = 8'h5A;
        if (push) begin
            e.d = d; e.bout = bout; e.zero = zero; e.acc = cyc;
            q8.push_back(e);
            check("w8 BUSY after accept", {31'd0, busy8}, 32'd1);
        end
    endtask

    task automatic go1(input logic a, input logic b, input logic d, input logic bout, input logic zero);
        exp_t e;
        start1 = 1'b1;
        a1 = a;
        b1 = b;
        @(posedge CLK);
        #2;
        start1 = 1'b0;
        e.d = {7'd0, d}; e.bout = bout; e.zero = zero; e.acc = cyc;
        q1.push_back(e);
        check("w1 BUSY after accept", {31'd0, busy1}, 32'd1);
    endtask

    int dc;

    initial begin
        tests = 0; failed = 0; cyc = 0; done_cnt8 = 0; done_cnt1 = 0;
        RST = 1'b1; start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        idle(2);
        RST = 1'b0;
        check("reset BUSY", {31'd0, busy8}, 32'd0);
        check("reset DONE", {31'd0, done8}, 32'd0);
        check("reset D", {24'd0, d8}, 32'd0);
        check("reset BOUT", {31'd0, bout8}, 32'd0);
        check("reset ZERO", {31'd0, zero8}, 32'd0);

        // Nominal, with explicit BUSY/DONE timing.
        go8(8'h5A, 8'h23, 1'b1, 8'h37, 1'b0, 1'b0);
        idle(7);
        check("nominal BUSY at edge 7", {31'd0, busy8}, 32'd1);
        check("nominal DONE at edge 7", {31'd0, done8}, 32'd0);
        idle(1);
        check("nominal BUSY at edge 8", {31'd0, busy8}, 32'd0);
        check("nominal DONE at edge 8", {31'd0, done8}, 32'd1);
        idle(2);

        // Borrow wrap cases.
        go8(8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0);
        idle(10);
        go8(8'h80, 8'h7F, 1'b1, 8'h01, 1'b0, 1'b0);
        idle(10);

        // Equal operands, then outputs hold through idle.
        go8(8'hC3, 8'hC3, 1'b1, 8'h00, 1'b0, 1'b1);
        idle(10);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("hold D", {24'd0, d8}, 32'd0);
            check("hold ZERO", {31'd0, zero8}, 32'd1);
        end

        // Busy protection: START during SHIFT and during FINISH both ignored.
        dc = done_cnt8;
        go8(8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, 1'b0);
        idle(2);
        go8(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(5);
        check("finish-cycle DONE", {31'd0, done8}, 32'd1);
        go8(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check("START in FINISH ignored", {31'd0, busy8}, 32'd0);
        idle(10);
        check("busy protect DONE count", done_cnt8 - dc, 32'd1);

        // Back-to-back: START in the cycle after DONE.
        go8(8'h33, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0);
        idle(9);
        go8(8'h44, 8'h45, 1'b1, 8'hFF, 1'b1, 1'b0);
        idle(10);

        // Reset mid-operation aborts without DONE.
        dc = done_cnt8;
        go8(8'h40, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        check("mid-op BUSY", {31'd0, busy8}, 32'd1);
        idle(3);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        check("abort BUSY", {31'd0, busy8}, 32'd0);
        check("abort D", {24'd0, d8}, 32'd0);
        check("abort BOUT", {31'd0, bout8}, 32'd0);
        check("abort DONE", {31'd0, done8}, 32'd0);
        idle(10);
        check("abort DONE count", done_cnt8 - dc, 32'd0);
        go8(8'h09, 8'h03, 1'b1, 8'h06, 1'b0, 1'b0);
        idle(10);

        // W=1 instance.
        go1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);
        go1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        go1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        check("w8 scoreboard drained", q8.size(), 32'd0);
        check("w1 scoreboard drained", q1.size(), 32'd0);
        check("w1 DONE count", done_cnt1, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
